irq_eoi_controller: RTL
=======================

// Module: irq_eoi_controller
// PURPOSE
//  Interrupt sequencer between the 16 IRQ input pads and the SOC core.
//  - Synchronises the pad IRQ lines and latches rising edges as pending.
//  - Arbitrates among unmasked pending lines and presents one ID at a time to the core.
//  - After the core signals completion, drives a timed pulse on that line's EOI output pad.
// PARAMETERS
//  N_IRQ        16  number of IRQ/EOI line pairs
//  ID_W         4   width of irq_id_o; must equal $clog2(N_IRQ)
//  SYNC_STAGES  2   synchroniser depth on each irq_i bit; minimum 2
//  EOI_CYCLES   4   EOI pad pulse length in clk cycles; range 1..255
// PORTS
//  clk          in   1      system clock; single clock domain
//  rst          in   1      synchronous, active-high reset
//  irq_i        in   N_IRQ  raw IRQ lines from the gpio_input pads (asynchronous)
//  mask_i       in   N_IRQ  1 = line not eligible for arbitration (still latches pending)
//  irq_valid_o  out  1      an interrupt is being presented to the core
//  irq_id_o     out  ID_W   ID of the presented interrupt
//  irq_ack_i    in   1      core accepts the presented ID
//  eoi_i        in   1      1-cycle pulse from the core: service of the accepted ID is done
//  eoi_o        out  N_IRQ  one-hot EOI pulses to the gpio_output pads
//  pending_o    out  N_IRQ  pending register, for visibility
//  busy_o       out  1      FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst high at a clk edge):
//   - Synchroniser flops, edge history, pending, FSM, counter and every output go to 0.
//   - irq_id_o resets to 0.
//   - A line that is high when reset is released is seen as a rising edge and becomes pending.
//   - Reset asserted mid-operation aborts immediately; any EOI pulse in progress ends the next cycle.
//  Input path:
//   - Each irq_i bit passes through SYNC_STAGES flops.
//   - A synced 0->1 transition sets pending[i] on the next edge.
//   - Latency: pad edge to pending_o is SYNC_STAGES+1 cycles (3 at defaults).
//   - When pending[i] is being set and cleared in the same cycle, the set wins.
//  Eligibility and arbitration:
//   - eligible = pending & ~mask_i; a winner is chosen only in IDLE.
//   - Fixed priority: the lowest eligible index wins.
//  FSM states:
//   - IDLE: if eligible != 0, latch the winner into irq_id_o and go to PRESENT.
//     irq_valid_o rises 1 cycle after pending_o.
//   - PRESENT: irq_valid_o=1; irq_id_o is held stable even if mask_i or pending change.
//     On irq_ack_i: clear pending[id], drop irq_valid_o, go to SERVICE.
//   - SERVICE: wait for eoi_i. Then load the counter with EOI_CYCLES and go to EOI.
//   - EOI: eoi_o[id]=1 for exactly EOI_CYCLES cycles, then go to IDLE.
//     A new presentation can start in the IDLE cycle that follows.
//  Ignored inputs:
//   - irq_ack_i outside PRESENT and eoi_i outside SERVICE are ignored.
//   - irq_ack_i and eoi_i together in PRESENT: only the ack takes effect; the EOI is dropped.
//  Other rules:
//   - A line that re-fires while it is in service becomes pending again and is re-arbitrated
//     after returning to IDLE.
//   - Edges arriving during SERVICE/EOI are never lost.
//   - eoi_o is one-hot or zero at all times.
//   - busy_o = (state != IDLE).
// CONFIGURATION
//  Macro IRQ_ROUND_ROBIN_EN:
//   - Defined: round-robin arbitration. A last-granted pointer (reset 0) is updated on each
//     irq_ack_i. Search starts at pointer+1 mod N_IRQ; the first eligible index wins.
//   - Undefined: fixed priority as above, and no pointer register exists.
// STRUCTURE
//  Package irq_ctrl_pkg:
//   - typedef irq_id_t = logic [ID_W-1:0]
//   - enum ctrl_state_e {IDLE, PRESENT, SERVICE, EOI}
//   - localparam N_IRQ_DEF = 16
//  Sub-module irq_sync: a SYNC_STAGES-deep bit synchroniser plus rising-edge detector,
//  instantiated once, N_IRQ bits wide.
//  Everything else (pending register, arbiter function, FSM, EOI counter) is in this module.
// TESTING
//  1. Reset; pulse irq_i[5] high for 1 cycle -> pending_o[5] after 3 cycles;
//     irq_valid_o=1, irq_id_o=5 one cycle later.
//  2. irq_i[3] and irq_i[9] rise together, fixed priority -> ID 3 presented first.
//     Then ack, eoi_i -> eoi_o[3] high exactly 4 cycles -> ID 9 presented.
//  3. mask_i[2]=1, irq_i[2] rises -> pending_o[2]=1, no irq_valid_o.
//     Clear the mask -> ID 2 presented the next cycle.
//  4. With IRQ_ROUND_ROBIN_EN: hold lines 1 and 4 re-firing -> grants alternate 1,4,1,4.
//  5. irq_i[7] re-rises during SERVICE of ID 7 -> pending_o[7] stays/sets to 1;
//     ID 7 presented again after the EOI pulse.
//  6. rst asserted in the 2nd EOI cycle -> next cycle eoi_o=0, busy_o=0, pending_o=0.
//     Stray eoi_i in IDLE -> no eoi_o activity.

Source files
------------

// File: rtl/irq_eoi_controller_pkg.sv
// rtl/irq_eoi_controller_pkg.sv - shared types and default sizes for the IRQ/EOI sequencer
package irq_ctrl_pkg;

  localparam int N_IRQ_DEF       = 16;
  localparam int ID_W_DEF        = $clog2(N_IRQ_DEF);
  localparam int SYNC_STAGES_DEF = 2;
  localparam int EOI_CYCLES_DEF  = 4;

  typedef logic [ID_W_DEF-1:0] irq_id_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    SERVICE,
    EOI
  } ctrl_state_e;

endpackage

// File: rtl/irq_eoi_controller_if.sv
// rtl/irq_eoi_controller_if.sv - pad and core-side signal bundle of the IRQ/EOI sequencer
interface irq_eoi_controller_if #(
  parameter int N_IRQ = irq_ctrl_pkg::N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ)
);
  import irq_ctrl_pkg::*;

  logic [N_IRQ-1:0] irq_i;
  logic [N_IRQ-1:0] mask_i;
  logic             irq_valid_o;
  logic [ID_W-1:0]  irq_id_o;
  logic             irq_ack_i;
  logic             eoi_i;
  logic [N_IRQ-1:0] eoi_o;
  logic [N_IRQ-1:0] pending_o;
  logic             busy_o;

  modport master (
    input  irq_i, mask_i, irq_ack_i, eoi_i,
    output irq_valid_o, irq_id_o, eoi_o, pending_o, busy_o
  );

  modport slave (
    output irq_i, mask_i, irq_ack_i, eoi_i,
    input  irq_valid_o, irq_id_o, eoi_o, pending_o, busy_o
  );

endinterface

// File: rtl/irq_eoi_controller_sync.sv
// rtl/irq_eoi_controller_sync.sv - multi-flop synchroniser with rising-edge detect per bit
module irq_sync
  import irq_ctrl_pkg::*;
#(
  parameter int W      = N_IRQ_DEF,
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] stage [STAGES];
  logic [W-1:0] last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) stage[s] <= '0;
      last <= '0;
    end else begin
      stage[0] <= din;
      for (int s = 1; s < STAGES; s++) stage[s] <= stage[s-1];
      last <= stage[STAGES-1];
    end
  end

  // last is cleared by reset, so a line already high at release reads as an edge
  assign rise = stage[STAGES-1] & ~last;

endmodule

// File: rtl/irq_eoi_controller.sv
// rtl/irq_eoi_controller.sv - IRQ pending/arbitration/EOI pulse sequencer
// Optional IRQ_ROUND_ROBIN_EN selects round-robin instead of lowest-index-first arbitration.
module irq_eoi_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int ID_W        = $clog2(N_IRQ),
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int EOI_CYCLES  = EOI_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  irq_eoi_controller_if.master  bus
);

  ctrl_state_e      state;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clear;
  logic [N_IRQ-1:0] eoi_q;
  logic [ID_W-1:0]  irq_id;
  logic [ID_W-1:0]  winner;
  logic [7:0]       eoi_cnt;
  logic             valid_q;
  logic             ack_taken;

  irq_sync #(.W(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.irq_i),
    .rise (rise)
  );

  assign eligible  = pending & ~bus.mask_i;
  assign ack_taken = (state == PRESENT) && bus.irq_ack_i;
  assign clear     = ack_taken ? (N_IRQ'(1) << irq_id) : '0;

  // A fresh edge on the line being acknowledged keeps it pending
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clear) | rise;
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_grant;

  function automatic logic [ID_W-1:0] pick_rr(input logic [N_IRQ-1:0] e,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_IRQ; k++) begin
      idx = (int'(last) + k) % N_IRQ;
      if (!found && e[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)            last_grant <= '0;
    else if (ack_taken) last_grant <= irq_id;
  end

  assign winner = pick_rr(eligible, last_grant);
`else
  function automatic logic [ID_W-1:0] pick_fixed(input logic [N_IRQ-1:0] e);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (e[i]) w = ID_W'(i);
    end
    return w;
  endfunction

  assign winner = pick_fixed(eligible);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_id  <= '0;
      valid_q <= 1'b0;
      eoi_q   <= '0;
      eoi_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            irq_id  <= winner;
            valid_q <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.irq_ack_i) begin
            valid_q <= 1'b0;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.eoi_i) begin
            eoi_cnt <= 8'(EOI_CYCLES);
            eoi_q   <= N_IRQ'(1) << irq_id;
            state   <= EOI;
          end
        end
        EOI: begin
          // counter holds the number of pulse cycles still to be shown, including this one
          if (eoi_cnt == 8'd1) begin
            eoi_q   <= '0;
            eoi_cnt <= '0;
            state   <= IDLE;
          end else begin
            eoi_cnt <= eoi_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_valid_o = valid_q;
  assign bus.irq_id_o    = irq_id;
  assign bus.eoi_o       = eoi_q;
  assign bus.pending_o   = pending;
  assign bus.busy_o      = (state != IDLE);

endmodule
